file_data_fifo_bridge: RTL
==========================

FILE_DATA_FIFO_BRIDGE -- requirements
Module: file_data_fifo_bridge

Interface
REQ-001 Parameters SHALL be: DATA_W, default 32, word width; DEPTH_LOG2, default 9, FIFO depth = 2**DEPTH_LOG2 words; LOW_WM, default 128, refill-assert level; HIGH_WM, default 384, refill-release level, LOW_WM < HIGH_WM <= depth.
REQ-002 clk_clk  input  1  single clock, all logic rising-edge.
REQ-003 reset_reset_n  input  1  asynchronous, active-low reset.
REQ-004 wr_data  input  DATA_W  word pushed from the HPS side.
REQ-005 wr_valid  input  1  push request.
REQ-006 wr_ready  output  1  push accepted when wr_valid & wr_ready.
REQ-007 file_data_read  input  1  Avalon-MM read strobe from the consumer.
REQ-008 file_data_readdata  output  DATA_W  head word.
REQ-009 file_data_waitrequest  output  1  stall; the read completes in the cycle where read & !waitrequest.
REQ-010 flush  input  1  synchronous FIFO clear.
REQ-011 level  output  DEPTH_LOG2+1  words stored.
REQ-012 refill_req  output  1  HPS refill request.
REQ-013 refill_reqid  output  16  request sequence number.
REQ-014 underrun_cnt  output  16  saturating underrun counter.

Function
REQ-015 wr_ready SHALL equal !full, where full means level == 2**DEPTH_LOG2; a pop in the same cycle SHALL NOT raise wr_ready when full.
REQ-016 file_data_waitrequest SHALL equal !head_valid, where head_valid means a word is present in the show-ahead head register.
REQ-017 file_data_readdata SHALL present the head word combinationally from a register; it SHALL be stable while waitrequest is high.
REQ-018 Write-to-read latency into an empty FIFO SHALL be 1 cycle: a push at cycle N clears waitrequest at cycle N+1.
REQ-019 A simultaneous push and pop SHALL leave level unchanged and preserve FIFO order.
REQ-020 level SHALL count the head register plus RAM words; it SHALL increment on push-only, decrement on pop-only and never wrap.
REQ-021 RAM read/write pointers SHALL be DEPTH_LOG2 bits and wrap modulo depth.
REQ-022 flush SHALL have priority over push and pop in the same cycle: pointers zeroed, level 0, head_valid 0, and that cycle's push discarded.
REQ-023 flush SHALL NOT alter underrun_cnt or refill_reqid.
REQ-024 Refill FSM states: FILL_IDLE and FILL_REQ. refill_req SHALL be 1 only in FILL_REQ.
REQ-025 FILL_IDLE SHALL move to FILL_REQ when level <= LOW_WM, and refill_reqid SHALL increment (mod 2**16) on that transition.
REQ-026 FILL_REQ SHALL move to FILL_IDLE when level >= HIGH_WM; otherwise it SHALL hold.
REQ-027 FSM decisions SHALL use the registered level, giving refill_req a 1-cycle lag after the level crosses.
REQ-028 underrun_cnt SHALL increment once per cycle with file_data_read & waitrequest & (level == 0), and SHALL saturate at 0xFFFF.

Reset
REQ-029 Asynchronous assertion SHALL force: level 0, pointers 0, head_valid 0, file_data_readdata 0, file_data_waitrequest 1, wr_ready 0, FSM FILL_IDLE, refill_req 0, refill_reqid 0, underrun_cnt 0.
REQ-030 wr_ready SHALL rise 1 cycle after reset release; the FSM SHALL enter FILL_REQ on the first cycle after release (level 0 <= LOW_WM), and refill_reqid SHALL become 1.
REQ-031 Reset mid-transfer SHALL discard all stored words without emitting a read completion.

Structure
REQ-032 Package file_data_pkg SHALL hold the fill_state_t enum (FILL_IDLE, FILL_REQ), the REQID_W=16 and UNDERRUN_W=16 constants, and the default parameter values.
REQ-033 Storage SHALL be the sub-module sdp_ram: simple dual-port, registered read, one write and one read port, DATA_W x 2**DEPTH_LOG2, with no reset on the array.
REQ-034 The head-register prefetch and the FSM SHALL reside in file_data_fifo_bridge.

Verification (DEPTH_LOG2=4, LOW_WM=4, HIGH_WM=12)
REQ-035 Reset release with no writes -> cycle 1: wr_ready=1, waitrequest=1; refill_req=1 with refill_reqid=1.
REQ-036 Push 0xA0..0xAF back-to-back -> level 16, wr_ready=0; a 17th push is ignored; 16 reads return 0xA0..0xAF in order.
REQ-037 Level 8 with simultaneous push and pop for 20 cycles -> level stays 8 and data order is preserved.
REQ-038 Fill to 12 -> refill_req=0; pop down to 4 -> refill_req=1 one cycle later and refill_reqid increments by 1.
REQ-039 Read held high on an empty FIFO for 5 cycles -> underrun_cnt=5, then one push completes the read with that data at the next cycle.
REQ-040 flush asserted with a concurrent push at level 7 -> next cycle level 0, waitrequest 1, pushed word lost, refill_reqid unchanged.

Source files
------------

// File: rtl/file_data_fifo_bridge_pkg.sv
// Shared types and defaults for the file-data FIFO bridge.
package file_data_pkg;

  typedef enum logic [0:0] {
    FILL_IDLE = 1'b0,
    FILL_REQ  = 1'b1
  } fill_state_t;

  localparam int REQID_W    = 16;
  localparam int UNDERRUN_W = 16;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_DEPTH_LOG2 = 9;
  localparam int DEF_LOW_WM     = 128;
  localparam int DEF_HIGH_WM    = 384;

endpackage

// File: rtl/file_data_fifo_bridge_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port, no array reset.
module sdp_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9
) (
  input  logic              i_clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];

  // Write port plus always-enabled registered read (read-before-write on collision)
  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    o_rd_data <= r_mem[i_rd_addr];
  end

endmodule

// File: rtl/file_data_fifo_bridge.sv
// Show-ahead FIFO bridging HPS pushes to an Avalon-MM read slave, with a
// watermark-driven refill request FSM and a saturating underrun counter.
//
// state     | meaning
// ----------+----------------------------------------------------------
// FILL_IDLE | enough data buffered, no refill requested
// FILL_REQ  | level fell to LOW_WM, refill_req held until HIGH_WM reached
module file_data_fifo_bridge
  import file_data_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
  parameter int LOW_WM     = DEF_LOW_WM,
  parameter int HIGH_WM    = DEF_HIGH_WM
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset_n,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic                  file_data_read,
  output logic [DATA_W-1:0]     file_data_readdata,
  output logic                  file_data_waitrequest,
  input  logic                  flush,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  refill_req,
  output logic [REQID_W-1:0]    refill_reqid,
  output logic [UNDERRUN_W-1:0] underrun_cnt
);

  localparam int LVL_W = DEPTH_LOG2 + 1;
  localparam logic [LVL_W-1:0]      C_FULL    = LVL_W'(1 << DEPTH_LOG2);
  localparam logic [LVL_W-1:0]      C_LOW     = LVL_W'(LOW_WM);
  localparam logic [LVL_W-1:0]      C_HIGH    = LVL_W'(HIGH_WM);
  localparam logic [LVL_W-1:0]      C_LVL_ONE = LVL_W'(1);
  localparam logic [DEPTH_LOG2-1:0] C_PTR_ONE = DEPTH_LOG2'(1);

  logic                  r_alive;
  logic [LVL_W-1:0]      r_level;
  logic                  r_head_valid;
  logic [DATA_W-1:0]     r_head;
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic                  r_byp_sel;
  logic [DATA_W-1:0]     r_byp_data;
  fill_state_t           r_state;
  fill_state_t           w_state_nxt;
  logic                  w_reqid_inc;
  logic [REQID_W-1:0]    r_reqid;
  logic [UNDERRUN_W-1:0] r_underrun;

  logic                  w_full;
  logic                  w_push;
  logic                  w_pop;
  logic [LVL_W-1:0]      w_ram_cnt;
  logic                  w_ram_empty;
  logic                  w_head_load;
  logic                  w_head_from_ram;
  logic                  w_head_from_wr;
  logic                  w_ram_wr;
  logic [DEPTH_LOG2-1:0] w_ram_rd_addr;
  logic [DATA_W-1:0]     w_ram_q;
  logic [DATA_W-1:0]     w_ram_data;

  assign w_full      = (r_level == C_FULL);
  assign wr_ready    = r_alive && !w_full;
  assign w_push      = wr_valid && wr_ready;
  assign w_pop       = file_data_read && r_head_valid;
  assign w_ram_cnt   = r_level - LVL_W'(r_head_valid);
  assign w_ram_empty = (w_ram_cnt == '0);

  // The head slot refills when empty or consumed; RAM words take precedence
  // over a new push so that FIFO order is kept.
  assign w_head_load     = !r_head_valid || w_pop;
  assign w_head_from_ram = w_head_load && !w_ram_empty;
  assign w_head_from_wr  = w_head_load && w_ram_empty && w_push;
  assign w_ram_wr        = w_push && !w_head_from_wr && !flush;

  // Read address looks one word ahead so the RAM output always holds the
  // word at the (next) read pointer, ready for the following head load.
  assign w_ram_rd_addr = flush ? '0 :
                         (w_head_from_ram ? (r_rd_ptr + C_PTR_ONE) : r_rd_ptr);

  // A word written to the address being read this cycle is not yet visible
  // on the registered read port; forward it from the bypass register.
  assign w_ram_data = r_byp_sel ? r_byp_data : w_ram_q;

  assign file_data_readdata    = r_head;
  assign file_data_waitrequest = !r_head_valid;
  assign level                 = r_level;
  assign refill_req            = (r_state == FILL_REQ);
  assign refill_reqid          = r_reqid;
  assign underrun_cnt          = r_underrun;

  sdp_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (DEPTH_LOG2)
  ) u_ram (
    .i_clk     (clk_clk),
    .i_wr_en   (w_ram_wr),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (wr_data),
    .i_rd_addr (w_ram_rd_addr),
    .o_rd_data (w_ram_q)
  );

  // Datapath state: head register, pointers, level and write bypass
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_alive      <= 1'b0;
      r_level      <= '0;
      r_head_valid <= 1'b0;
      r_head       <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_byp_sel    <= 1'b0;
      r_byp_data   <= '0;
    end else begin
      r_alive    <= 1'b1;
      r_byp_sel  <= w_ram_wr && (r_wr_ptr == w_ram_rd_addr);
      r_byp_data <= wr_data;
      if (flush) begin
        r_level      <= '0;
        r_head_valid <= 1'b0;
        r_wr_ptr     <= '0;
        r_rd_ptr     <= '0;
      end else begin
        if (w_head_from_ram) begin
          r_head       <= w_ram_data;
          r_head_valid <= 1'b1;
          r_rd_ptr     <= r_rd_ptr + C_PTR_ONE;
        end else if (w_head_from_wr) begin
          r_head       <= wr_data;
          r_head_valid <= 1'b1;
        end else if (w_pop) begin
          r_head_valid <= 1'b0;
        end
        if (w_ram_wr) r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
        if (w_push && !w_pop)      r_level <= r_level + C_LVL_ONE;
        else if (w_pop && !w_push) r_level <= r_level - C_LVL_ONE;
      end
    end
  end

  // Saturating count of cycles where the consumer reads an empty FIFO
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_underrun <= '0;
    end else if (file_data_read && !r_head_valid && (r_level == '0) && (r_underrun != '1)) begin
      r_underrun <= r_underrun + UNDERRUN_W'(1);
    end
  end

  // Refill FSM state register and request sequence number
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_state <= FILL_IDLE;
      r_reqid <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_reqid_inc) r_reqid <= r_reqid + REQID_W'(1);
    end
  end

  // Refill FSM next-state from the registered level
  always_comb begin
    w_state_nxt = r_state;
    w_reqid_inc = 1'b0;
    case (r_state)
      FILL_IDLE: begin
        if (r_level <= C_LOW) begin
          w_state_nxt = FILL_REQ;
          w_reqid_inc = 1'b1;
        end
      end
      FILL_REQ: begin
        if (r_level >= C_HIGH) w_state_nxt = FILL_IDLE;
      end
      default: w_state_nxt = FILL_IDLE;
    endcase
  end

endmodule
